// File: rtl/msrv_32_fetch_ctrl.sv
// msrv_32 instruction fetch controller: imem request/ack sequencing, fetch PC
// generation and a small instruction buffer feeding the instruction mux.
module msrv_32_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               push, pop;
  fetch_entry_t       mem_q [FIFO_DEPTH];
  fetch_entry_t       head;
  logic               empty;

  // State and buffer bookkeeping registers
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC_A;
      addr_q     <= RESET_PC_A;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are don't-care while count is zero
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push && !ms_riscv32_mp_rst_in) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_rdata_in};
    end
  end

  // Next-state, fetch PC and buffer pointer logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    addr_d     = addr_q;
    pop        = (count_q != '0) && !stall_in && !redirect_in;
    push       = (state_q == REQ) && imem_ack_in && !redirect_in;

    if (redirect_in) begin
      // Redirect empties the buffer and retargets fetch
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc_in & ALIGN_MASK;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end

    case (state_q)
      IDLE: begin
        if (count_d < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_in) begin
          state_d = imem_ack_in ? REQ : DRAIN;
        end else if (imem_ack_in) begin
          state_d = (count_d < DEPTH_C) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack_in) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // The bus address only moves once the outstanding request is acked
    addr_d = (state_d == DRAIN) ? addr_q : fetch_pc_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);

  assign imem_req_out    = (state_q != IDLE);
  assign imem_addr_out   = addr_q;
  assign instr_out       = empty ? NOP_INSTR : head.instr;
  assign pc_out          = empty ? fetch_pc_q : head.pc;
  assign instr_valid_out = !empty && !redirect_in && !ms_riscv32_mp_rst_in;
  assign flush_out       = empty || redirect_in || ms_riscv32_mp_rst_in;

endmodule

// File: tb/tb_msrv_32_fetch_ctrl.sv
// Directed self-checking bench for msrv_32_fetch_ctrl (RESET_PC=0, FIFO_DEPTH=2).
module tb_msrv_32_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  msrv_32_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .imem_req_out        (req),
    .imem_addr_out       (addr),
    .imem_ack_in         (ack),
    .imem_rdata_in       (rdata),
    .redirect_in         (redirect),
    .redirect_pc_in      (redirect_pc),
    .stall_in            (stall),
    .instr_out           (instr),
    .pc_out              (pc),
    .instr_valid_out     (valid),
    .flush_out           (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and step into the first request at RESET_PC
  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; rdata = '0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values
    rst = 1'b1; ack = 1'b0; rdata = '0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    tick();
    tick();
    #2;
    check("rst_req",   32'(req),   32'd0);
    check("rst_addr",  addr,       32'h0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd1);
    check("rst_instr", instr,      NOP);
    check("rst_pc",    pc,         32'h0);

    // 1: streaming fetch, ack every cycle
    rst = 1'b0;
    tick();
    #2;
    check("t1_flush_empty", 32'(flush), 32'd1);
    check("t1_valid_empty", 32'(valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1;
      rdata = 32'h100 + 32'(i);
      #2;
      check("t1_addr", addr, 32'(4 * i));
      check("t1_req",  32'(req), 32'd1);
      tick();
      #2;
      check("t1_instr", instr, 32'h100 + 32'(i));
      check("t1_pc",    pc,    32'(4 * i));
      check("t1_valid", 32'(valid), 32'd1);
      check("t1_flush", 32'(flush), 32'd0);
    end

    // 2: stall fills the buffer, then release
    do_reset();
    stall = 1'b1; ack = 1'b1; rdata = 32'h200;
    #2;
    check("t2_addr0", addr, 32'h0);
    tick();
    rdata = 32'h204;
    #2;
    check("t2_addr4", addr, 32'h4);
    check("t2_head_instr", instr, 32'h200);
    check("t2_head_pc", pc, 32'h0);
    tick();
    ack = 1'b0;
    #2;
    check("t2_full_noreq", 32'(req), 32'd0);
    check("t2_hold_pc", pc, 32'h0);
    tick();
    #2;
    check("t2_still_noreq", 32'(req), 32'd0);
    check("t2_still_pc", pc, 32'h0);
    stall = 1'b0;
    tick();
    #2;
    check("t2_reissue_req", 32'(req), 32'd1);
    check("t2_reissue_addr", addr, 32'h8);
    check("t2_next_pc", pc, 32'h4);
    check("t2_next_instr", instr, 32'h204);

    // 3: redirect while request to 0x8 is outstanding
    redirect = 1'b1; redirect_pc = 32'h2000;
    #2;
    check("t3_valid_redir", 32'(valid), 32'd0);
    check("t3_flush_redir", 32'(flush), 32'd1);
    tick();
    redirect = 1'b0;
    #2;
    check("t3_drain_req", 32'(req), 32'd1);
    check("t3_drain_addr", addr, 32'h8);
    check("t3_drain_flush", 32'(flush), 32'd1);
    check("t3_drain_instr", instr, NOP);
    tick();
    #2;
    check("t3_drain_addr2", addr, 32'h8);
    tick();
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    #2;
    check("t3_drain_addr3", addr, 32'h8);
    tick();
    ack = 1'b0;
    #2;
    check("t3_new_addr", addr, 32'h2000);
    check("t3_new_req", 32'(req), 32'd1);
    check("t3_dropped_valid", 32'(valid), 32'd0);
    check("t3_dropped_instr", instr, NOP);
    check("t3_pc_empty", pc, 32'h2000);

    // 4: redirect coincident with ack of 0xC
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1;
      rdata = 32'h400 + 32'(i);
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h41; ack = 1'b1; rdata = 32'h4FF;
    #2;
    check("t4_addr_c", addr, 32'hC);
    check("t4_valid", 32'(valid), 32'd0);
    check("t4_flush", 32'(flush), 32'd1);
    tick();
    redirect = 1'b0; ack = 1'b0;
    #2;
    check("t4_new_addr", addr, 32'h40);
    check("t4_req", 32'(req), 32'd1);
    check("t4_not_pushed", 32'(valid), 32'd0);
    check("t4_nop", instr, NOP);

    // 5: reset mid-transaction with a buffered entry
    do_reset();
    stall = 1'b1; ack = 1'b1; rdata = 32'h500;
    tick();
    ack = 1'b0;
    tick();
    #2;
    check("t5_outstanding_req", 32'(req), 32'd1);
    check("t5_outstanding_addr", addr, 32'h4);
    check("t5_buffered_valid", 32'(valid), 32'd1);
    rst = 1'b1;
    tick();
    #2;
    check("t5_rst_req", 32'(req), 32'd0);
    check("t5_rst_addr", addr, 32'h0);
    check("t5_rst_valid", 32'(valid), 32'd0);
    check("t5_rst_flush", 32'(flush), 32'd1);
    check("t5_rst_instr", instr, NOP);
    check("t5_rst_pc", pc, 32'h0);
    ack = 1'b1; rdata = 32'hBAD0_0BAD;
    tick();
    rst = 1'b0;
    #2;
    check("t5_late_ack_req", 32'(req), 32'd0);
    tick();
    ack = 1'b0;
    #2;
    check("t5_restart_addr", addr, 32'h0);
    check("t5_restart_req", 32'(req), 32'd1);
    check("t5_late_ack_ignored", 32'(valid), 32'd0);
    stall = 1'b0;

    // 6: redirect to top of address space, fetch wraps
    ack = 1'b1; rdata = 32'h777; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; rdata = 32'h600;
    #2;
    check("t6_addr_top", addr, 32'hFFFF_FFFC);
    check("t6_empty", 32'(valid), 32'd0);
    tick();
    rdata = 32'h601;
    #2;
    check("t6_addr_wrap", addr, 32'h0);
    check("t6_instr_top", instr, 32'h600);
    check("t6_pc_top", pc, 32'hFFFF_FFFC);
    tick();
    ack = 1'b0;
    #2;
    check("t6_instr_wrap", instr, 32'h601);
    check("t6_pc_wrap", pc, 32'h0);
    check("t6_addr_next", addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
